// File: rtl/sdram_test_sequencer.sv
// sdram_test_sequencer: debounces the test push-button, drives the ordered
// software-reset / FIFO-load / start strobe sequence for the SDRAM controller
// and RW test engine, waits for completion and keeps pass/fail statistics.
module sdram_test_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SW_RST_CYCLES   = 16,
    parameter int unsigned LOAD_CYCLES     = 16,
    parameter int unsigned SETTLE_CYCLES   = 256,
    parameter int unsigned START_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 0,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iKEY_n,
    input  logic             iLOOP,
    input  logic             iTEST_COMPLETE,
    input  logic             iTEST_PASS,
    input  logic             iTEST_FAIL,
    output logic             oSW_RST_n,
    output logic             oLOAD_n,
    output logic             oSTART_n,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oLAST_PASS,
    output logic [CNT_W-1:0] oPASS_CNT,
    output logic [CNT_W-1:0] oFAIL_CNT
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SW_RST,
        S_LOAD,
        S_SETTLE,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    state_t          state, state_next;
    logic [31:0]     tmr, tmr_next;
    logic            armed;
    logic            result;

    logic            key_meta, key_sync, key_db;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    // Two-flop synchroniser for the asynchronous push-button.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= iKEY_n;
            key_sync <= key_meta;
        end
    end

    // Debounce: accept a new level only after it has persisted for
    // DEBOUNCE_CYCLES consecutive cycles; any return clears the count.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_sync != key_db) begin
            if (db_cnt == DB_LAST) begin
                key_db <= key_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Press strobe: high for the single cycle in which the debounced key falls.
    assign press = key_db && !key_sync && (db_cnt == DB_LAST);

    // Next-state logic; tmr is a down-counter in the timed states and an
    // up-counter of elapsed cycles in RUN.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        result     = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    state_next = S_SW_RST;
                    tmr_next   = SW_RST_CYCLES - 1;
                end
            end
            S_SW_RST: begin
                if (tmr == 32'd0) begin
                    state_next = S_LOAD;
                    tmr_next   = LOAD_CYCLES - 1;
                end else begin
                    tmr_next = tmr - 32'd1;
                end
            end
            S_LOAD: begin
                if (tmr == 32'd0) begin
                    state_next = S_SETTLE;
                    tmr_next   = SETTLE_CYCLES - 1;
                end else begin
                    tmr_next = tmr - 32'd1;
                end
            end
            S_SETTLE: begin
                if (tmr == 32'd0) begin
                    state_next = S_START;
                    tmr_next   = START_CYCLES - 1;
                end else begin
                    tmr_next = tmr - 32'd1;
                end
            end
            S_START: begin
                if (tmr == 32'd0) begin
                    state_next = S_RUN;
                    tmr_next   = 32'd0;
                end else begin
                    tmr_next = tmr - 32'd1;
                end
            end
            S_RUN: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (armed && iTEST_COMPLETE) begin
                    state_next = S_REPORT;
                    result     = iTEST_PASS & ~iTEST_FAIL;
                end else if ((TIMEOUT_CYCLES != 0) && (tmr == TIMEOUT_CYCLES - 1)) begin
                    state_next = S_REPORT;
                    result     = 1'b0;
                end else begin
                    tmr_next = tmr + 32'd1;
                end
            end
            S_REPORT: begin
                if (iLOOP) begin
                    state_next = S_SW_RST;
                    tmr_next   = SW_RST_CYCLES - 1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A press while busy aborts the run and restarts the full sequence.
        if (press && (state != S_IDLE)) begin
            state_next = S_SW_RST;
            tmr_next   = SW_RST_CYCLES - 1;
        end
    end

    // State, timer and the stale-completion guard.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= S_IDLE;
            tmr   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            armed <= (state_next == S_RUN) && (state == S_RUN) &&
                     (armed || !iTEST_COMPLETE);
        end
    end

    // Registered outputs decoded from the next state, so each strobe is
    // low for exactly the cycles its state is occupied.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oSW_RST_n <= 1'b1;
            oLOAD_n   <= 1'b1;
            oSTART_n  <= 1'b1;
            oBUSY     <= 1'b0;
            oDONE     <= 1'b0;
        end else begin
            oSW_RST_n <= (state_next != S_SW_RST);
            oLOAD_n   <= (state_next != S_LOAD);
            oSTART_n  <= (state_next != S_START);
            oBUSY     <= (state_next != S_IDLE);
            oDONE     <= (state_next == S_REPORT);
        end
    end

    // Result recording on entry to REPORT; counters saturate at all-ones.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oLAST_PASS <= 1'b0;
            oPASS_CNT  <= '0;
            oFAIL_CNT  <= '0;
        end else if (state_next == S_REPORT) begin
            oLAST_PASS <= result;
            if (result) begin
                if (oPASS_CNT != '1) oPASS_CNT <= oPASS_CNT + 1'b1;
            end else begin
                if (oFAIL_CNT != '1) oFAIL_CNT <= oFAIL_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Directed bench for sdram_test_sequencer with short timing parameters,
// a 50-cycle RUN timeout and 2-bit counters.
module tb_sdram_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic       loop_en;
    logic       test_complete;
    logic       test_pass;
    logic       test_fail;
    logic       sw_rst_n;
    logic       load_n;
    logic       start_n;
    logic       busy;
    logic       done;
    logic       last_pass;
    logic [1:0] pass_cnt;
    logic [1:0] fail_cnt;

    int errors = 0;
    int checks = 0;

    sdram_test_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .SW_RST_CYCLES  (4),
        .LOAD_CYCLES    (4),
        .SETTLE_CYCLES  (6),
        .START_CYCLES   (2),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (2)
    ) dut (
        .iCLK          (clk),
        .iRST_n        (rst_n),
        .iKEY_n        (key_n),
        .iLOOP         (loop_en),
        .iTEST_COMPLETE(test_complete),
        .iTEST_PASS    (test_pass),
        .iTEST_FAIL    (test_fail),
        .oSW_RST_n     (sw_rst_n),
        .oLOAD_n       (load_n),
        .oSTART_n      (start_n),
        .oBUSY         (busy),
        .oDONE         (done),
        .oLAST_PASS    (last_pass),
        .oPASS_CNT     (pass_cnt),
        .oFAIL_CNT     (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0: sw_rst low, 1: load low, 2: start low, 3: all strobes high
    function automatic logic strobe_cond(input int which);
        case (which)
            0:       return sw_rst_n === 1'b0;
            1:       return load_n === 1'b0;
            2:       return start_n === 1'b0;
            default: return (sw_rst_n === 1'b1) && (load_n === 1'b1) && (start_n === 1'b1);
        endcase
    endfunction

    task automatic measure(input int which, output int len);
        len = 0;
        while (strobe_cond(which) && len < 100) begin
            @(negedge clk);
            len++;
        end
    endtask

    // Press the key and stop at the first sample showing the SW reset strobe.
    task automatic press_key();
        int n = 0;
        key_n = 1'b0;
        while (sw_rst_n !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("press_detect", {31'b0, sw_rst_n === 1'b0}, 32'd1);
        key_n = 1'b1;
    endtask

    // Advance to the first RUN-cycle sample (start strobe just released).
    task automatic wait_run_start();
        int n = 0;
        while (start_n !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        while (start_n === 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("run_start_seen", {31'b0, (n < 60) && (start_n === 1'b1) && (busy === 1'b1)}, 32'd1);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  len;
        int  n;
        logic bad;
        logic prev_sw, prev_idle, aborted, saw_start, saw_done;

        rst_n         = 1'b0;
        key_n         = 1'b1;
        loop_en       = 1'b0;
        test_complete = 1'b0;
        test_pass     = 1'b0;
        test_fail     = 1'b0;

        // Reset state
        #12;
        check("rst_sw_rst_n", {31'b0, sw_rst_n}, 32'd1);
        check("rst_load_n", {31'b0, load_n}, 32'd1);
        check("rst_start_n", {31'b0, start_n}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_last_pass", {31'b0, last_pass}, 32'd0);
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Bounce rejection: low 5 / high 1, ten times
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_n = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (busy !== 1'b0 || !strobe_cond(3)) bad = 1'b1;
            end
            key_n = 1'b1;
            @(negedge clk);
            if (busy !== 1'b0 || !strobe_cond(3)) bad = 1'b1;
        end
        tick(12);
        check("bounce_no_activity", {31'b0, bad}, 32'd0);
        check("bounce_idle", {31'b0, busy}, 32'd0);

        // Clean press: strobe sequence timing
        press_key();
        check("seq_busy_first_swrst", {31'b0, busy}, 32'd1);
        measure(0, len);
        check("seq_sw_rst_width", len, 32'd4);
        check("seq_load_follows", {31'b0, load_n}, 32'd0);
        measure(1, len);
        check("seq_load_width", len, 32'd4);
        measure(3, len);
        check("seq_settle_gap", len, 32'd6);
        measure(2, len);
        check("seq_start_width", len, 32'd2);
        check("seq_run_busy", {31'b0, busy}, 32'd1);

        // Passing run: complete low 3 cycles, then complete with pass
        test_complete = 1'b0;
        test_pass     = 1'b1;
        test_fail     = 1'b0;
        tick(3);
        test_complete = 1'b1;
        wait_done(10, n);
        check("pass_done_latency", n, 32'd1);
        check("pass_last_pass", {31'b0, last_pass}, 32'd1);
        check("pass_pass_cnt", 32'(pass_cnt), 32'd1);
        check("pass_fail_cnt", 32'(fail_cnt), 32'd0);
        tick(1);
        check("pass_done_one_cycle", {31'b0, done}, 32'd0);
        check("pass_back_idle", {31'b0, busy}, 32'd0);

        // Failing run
        press_key();
        wait_run_start();
        test_complete = 1'b0;
        test_pass     = 1'b0;
        test_fail     = 1'b1;
        tick(3);
        test_complete = 1'b1;
        wait_done(10, n);
        check("fail_done_latency", n, 32'd1);
        check("fail_last_pass", {31'b0, last_pass}, 32'd0);
        check("fail_fail_cnt", 32'(fail_cnt), 32'd1);
        check("fail_pass_cnt", 32'(pass_cnt), 32'd1);
        tick(1);

        // Stale completion held high through RUN: only the timeout ends it
        test_complete = 1'b1;
        test_pass     = 1'b1;
        test_fail     = 1'b0;
        press_key();
        wait_run_start();
        wait_done(200, n);
        check("timeout_run_cycles", n, 32'd50);
        check("timeout_fail_cnt", 32'(fail_cnt), 32'd2);
        check("timeout_pass_cnt", 32'(pass_cnt), 32'd1);
        check("timeout_last_pass", {31'b0, last_pass}, 32'd0);
        tick(1);

        // Asynchronous reset during LOAD
        press_key();
        n = 0;
        while (load_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("areset_in_load", {31'b0, load_n}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("areset_load_n", {31'b0, load_n}, 32'd1);
        check("areset_sw_rst_n", {31'b0, sw_rst_n}, 32'd1);
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_pass_cnt", 32'(pass_cnt), 32'd0);
        check("areset_fail_cnt", 32'(fail_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Loop mode: five passing runs, abort during SETTLE of run 4,
        // counter saturates at 3
        loop_en = 1'b1;
        press_key();
        for (int r = 1; r <= 5; r++) begin
            wait_run_start();
            test_complete = 1'b0;
            test_pass     = 1'b1;
            test_fail     = 1'b0;
            tick(2);
            if (r == 5) loop_en = 1'b0;
            test_complete = 1'b1;
            wait_done(10, n);
            check($sformatf("loop%0d_done_latency", r), n, 32'd1);
            check($sformatf("loop%0d_pass_cnt", r), 32'(pass_cnt), (r < 3) ? 32'(r) : 32'd3);
            tick(1);
            if (r < 5) begin
                check($sformatf("loop%0d_reenter_swrst", r), {31'b0, sw_rst_n}, 32'd0);
            end else begin
                check("loop_exit_idle", {31'b0, busy}, 32'd0);
            end

            if (r == 3) begin
                key_n     = 1'b0;
                prev_sw   = 1'b0;
                prev_idle = 1'b0;
                aborted   = 1'b0;
                saw_start = 1'b0;
                saw_done  = 1'b0;
                for (int c = 0; c < 30 && !aborted; c++) begin
                    prev_idle = strobe_cond(3);
                    @(negedge clk);
                    if (done === 1'b1) saw_done = 1'b1;
                    if (start_n === 1'b0) saw_start = 1'b1;
                    if (sw_rst_n === 1'b0 && prev_sw === 1'b1) aborted = 1'b1;
                    prev_sw = sw_rst_n;
                end
                key_n = 1'b1;
                check("abort_seen", {31'b0, aborted}, 32'd1);
                check("abort_from_settle", {31'b0, prev_idle && !saw_start}, 32'd1);
                check("abort_no_done", {31'b0, saw_done}, 32'd0);
                measure(0, len);
                check("abort_sw_rst_width", len, 32'd4);
                check("abort_pass_cnt", 32'(pass_cnt), 32'd3);
                check("abort_fail_cnt", 32'(fail_cnt), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
